// File: rtl/syn_fgyrus_pcm_fetch_if.sv
// Bus bundle between the PCM fetch block, the audio cache Fgyrus memory port
// and the FFT sample RAM / engine.
interface syn_fgyrus_pcm_fetch_if #(
    parameter int P_ADDR_W = 7,
    parameter int P_PCM_W  = 32
);
    logic                   mem_rd_en;
    logic [P_ADDR_W-1:0]    mem_addr;
    logic [P_PCM_W-1:0]     lchnnl_rdata;
    logic [P_PCM_W-1:0]     rchnnl_rdata;
    logic                   mem_rd_valid;
    logic                   fft_busy;
    logic                   fft_wr_en;
    logic [P_ADDR_W-1:0]    fft_wr_addr;
    logic [2*P_PCM_W-1:0]   fft_wr_data;
    logic                   fft_start_oh;

    modport master (
        output mem_rd_en, mem_addr, fft_wr_en, fft_wr_addr, fft_wr_data, fft_start_oh,
        input  lchnnl_rdata, rchnnl_rdata, mem_rd_valid, fft_busy
    );

    modport slave (
        input  mem_rd_en, mem_addr, fft_wr_en, fft_wr_addr, fft_wr_data, fft_start_oh,
        output lchnnl_rdata, rchnnl_rdata, mem_rd_valid, fft_busy
    );
endinterface

// File: rtl/syn_fgyrus_pcm_fetch.sv
// Copies one frame of L/R PCM sample pairs from the audio cache into the FFT
// sample RAM at bit-reversed addresses, then pulses the FFT engine to start.
module syn_fgyrus_pcm_fetch #(
    parameter int P_ADDR_W      = 7,
    parameter int P_NUM_SAMPLES = 128,
    parameter int P_PCM_W       = 32
) (
    input  logic                           clk_ir,
    input  logic                           rst_sync_l,
    input  logic                           pcm_data_rdy_oh,
    syn_fgyrus_pcm_fetch_if.master         bus,
    output logic                           busy,
    output logic [7:0]                     ovrn_cnt
);

    localparam int CNT_W = P_ADDR_W + 1;
    localparam logic [P_ADDR_W-1:0] LAST_REQ = P_ADDR_W'(P_NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0]    NUM_RSP  = CNT_W'(P_NUM_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FFT,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [P_ADDR_W-1:0]    req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]       rsp_cnt_q, rsp_cnt_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic                   fft_wr_en_q, fft_wr_en_d;
    logic [P_ADDR_W-1:0]    fft_wr_addr_q, fft_wr_addr_d;
    logic [2*P_PCM_W-1:0]   fft_wr_data_q, fft_wr_data_d;
    logic                   fft_start_oh_q, fft_start_oh_d;
    logic                   busy_q, busy_d;
    logic [7:0]             ovrn_cnt_q, ovrn_cnt_d;
    logic                   rsp_accept;

    function automatic logic [P_ADDR_W-1:0] bitrev(input logic [P_ADDR_W-1:0] v);
        logic [P_ADDR_W-1:0] r;
        for (int i = 0; i < P_ADDR_W; i++) begin
            r[i] = v[P_ADDR_W-1-i];
        end
        return r;
    endfunction

    // NOTE: every flop updates with <= so all registers see pre-edge values.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q        <= S_IDLE;
            req_cnt_q      <= '0;
            rsp_cnt_q      <= '0;
            mem_rd_en_q    <= 1'b0;
            fft_wr_en_q    <= 1'b0;
            fft_wr_addr_q  <= '0;
            fft_wr_data_q  <= '0;
            fft_start_oh_q <= 1'b0;
            busy_q         <= 1'b0;
            ovrn_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            req_cnt_q      <= req_cnt_d;
            rsp_cnt_q      <= rsp_cnt_d;
            mem_rd_en_q    <= mem_rd_en_d;
            fft_wr_en_q    <= fft_wr_en_d;
            fft_wr_addr_q  <= fft_wr_addr_d;
            fft_wr_data_q  <= fft_wr_data_d;
            fft_start_oh_q <= fft_start_oh_d;
            busy_q         <= busy_d;
            ovrn_cnt_q     <= ovrn_cnt_d;
        end
    end

    // NOTE: state_d defaults to state_q first so no path leaves it unassigned.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (pcm_data_rdy_oh) state_d = bus.fft_busy ? S_WAIT_FFT : S_FETCH;
            S_WAIT_FFT: if (!bus.fft_busy) state_d = S_FETCH;
            S_FETCH:    if (req_cnt_q == LAST_REQ) state_d = S_DRAIN;
            S_DRAIN:    if (rsp_cnt_q == NUM_RSP) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from state_d so each lands in its flop aligned with the state.
    always_comb begin
        req_cnt_d      = req_cnt_q;
        rsp_cnt_d      = rsp_cnt_q;
        fft_wr_addr_d  = fft_wr_addr_q;
        fft_wr_data_d  = fft_wr_data_q;
        ovrn_cnt_d     = ovrn_cnt_q;

        rsp_accept = ((state_q == S_FETCH) || (state_q == S_DRAIN)) &&
                     bus.mem_rd_valid && (rsp_cnt_q < NUM_RSP);

        // req_cnt doubles as mem_addr; it wraps to 0 after the last index.
        if (state_q == S_FETCH) req_cnt_d = req_cnt_q + 1'b1;

        if (rsp_accept) begin
            fft_wr_addr_d = bitrev(rsp_cnt_q[P_ADDR_W-1:0]);
            fft_wr_data_d = {bus.rchnnl_rdata, bus.lchnnl_rdata};
            rsp_cnt_d     = rsp_cnt_q + 1'b1;
        end

        if (state_q == S_DONE) begin
            req_cnt_d = '0;
            rsp_cnt_d = '0;
        end

        if (pcm_data_rdy_oh && (state_q != S_IDLE) && (ovrn_cnt_q != 8'hFF)) begin
            ovrn_cnt_d = ovrn_cnt_q + 8'd1;
        end

        mem_rd_en_d    = (state_d == S_FETCH);
        fft_wr_en_d    = rsp_accept;
        fft_start_oh_d = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
    end

    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_addr     = req_cnt_q;
    assign bus.fft_wr_en    = fft_wr_en_q;
    assign bus.fft_wr_addr  = fft_wr_addr_q;
    assign bus.fft_wr_data  = fft_wr_data_q;
    assign bus.fft_start_oh = fft_start_oh_q;
    assign busy             = busy_q;
    assign ovrn_cnt         = ovrn_cnt_q;

endmodule

// File: tb/tb_syn_fgyrus_pcm_fetch.sv
// Scoreboard bench for syn_fgyrus_pcm_fetch with an 8-sample frame and a
// latency-configurable cache model.
module tb_syn_fgyrus_pcm_fetch;

    localparam int AW = 3;
    localparam int NS = 8;
    localparam int PW = 32;

    typedef struct {
        bit          is_start;
        logic [2:0]  addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [2:0] addr;
        int         due;
    } req_t;

    logic       clk;
    logic       rst_sync_l;
    logic       rdy;
    logic       busy;
    logic [7:0] ovrn_cnt;

    syn_fgyrus_pcm_fetch_if #(.P_ADDR_W(AW), .P_PCM_W(PW)) bus_if ();

    syn_fgyrus_pcm_fetch #(.P_ADDR_W(AW), .P_NUM_SAMPLES(NS), .P_PCM_W(PW)) dut (
        .clk_ir          (clk),
        .rst_sync_l      (rst_sync_l),
        .pcm_data_rdy_oh (rdy),
        .bus             (bus_if),
        .busy            (busy),
        .ovrn_cnt        (ovrn_cnt)
    );

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   lat = 2;
    bit   bubble = 0;
    int   bub_base = 0;
    int   stray_req = 0;
    int   stray_ack = 0;
    int   rd_cnt = 0;
    int   rd_start_cyc = -1;
    int   wr_seen = 0;
    int   start_seen = 0;
    int   busy_fall_cyc = -1;
    int   br_tbl [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    exp_t sb [$];
    req_t rq [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Hand-derived frame: write k lands at br_tbl[k]; f is the first mem_rd_en cycle.
    task automatic expect_frame(input int f, input bit bub);
        exp_t e;
        for (int k = 0; k < NS; k++) begin
            e.is_start = 1'b0;
            e.addr     = 3'(br_tbl[k]);
            e.data     = {32'(32'h200 + k), 32'(32'h100 + k)};
            e.cyc      = bub ? (f + lat + 2*k + 1) : (f + lat + k + 1);
            sb.push_back(e);
        end
        e.is_start = 1'b1;
        e.addr     = '0;
        e.data     = '0;
        e.cyc      = bub ? (f + lat + 2*NS) : (f + NS + lat + 1);
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(name, 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Cache model: one response per read strobe, in order, lat cycles later.
    initial begin
        req_t r;
        bit   rd_prev = 1'b0;
        bus_if.mem_rd_valid = 1'b0;
        bus_if.lchnnl_rdata = '0;
        bus_if.rchnnl_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_if.mem_rd_en === 1'b1) begin
                r.addr = bus_if.mem_addr;
                r.due  = cyc + lat;
                rq.push_back(r);
                rd_cnt++;
                if (!rd_prev) rd_start_cyc = cyc;
                rd_prev = 1'b1;
            end else begin
                rd_prev = 1'b0;
            end
            bus_if.mem_rd_valid = 1'b0;
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                bus_if.mem_rd_valid = 1'b1;
                bus_if.lchnnl_rdata = 32'hDEAD_BEEF;
                bus_if.rchnnl_rdata = 32'hCAFE_F00D;
            end else if (rq.size() > 0 && rq[0].due <= cyc &&
                         (!bubble || ((cyc - bub_base) % 2) == 0)) begin
                r = rq.pop_front();
                bus_if.mem_rd_valid = 1'b1;
                bus_if.lchnnl_rdata = 32'h100 + {29'd0, r.addr};
                bus_if.rchnnl_rdata = 32'h200 + {29'd0, r.addr};
            end
        end
    end

    // Monitor: pops the scoreboard on every write or start pulse.
    initial begin
        exp_t e;
        bit   busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.fft_wr_en === 1'b1) begin
                wr_seen++;
                check("wr_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_kind", 64'(e.is_start), 64'd0);
                    check("wr_addr", 64'(bus_if.fft_wr_addr), 64'(e.addr));
                    check("wr_data", bus_if.fft_wr_data, e.data);
                    check("wr_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (bus_if.fft_start_oh === 1'b1) begin
                start_seen++;
                check("start_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("start_kind", 64'(e.is_start), 64'd1);
                    check("start_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (busy_prev && !busy) busy_fall_cyc = cyc;
            busy_prev = busy;
        end
    end

    initial begin
        int  t;
        int  snap_a;
        int  snap_b;
        bit  found;

        rst_sync_l      = 1'b0;
        rdy             = 1'b0;
        bus_if.fft_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_rd_en",   64'(bus_if.mem_rd_en),    64'd0);
        check("rst_mem_addr",    64'(bus_if.mem_addr),     64'd0);
        check("rst_fft_wr_en",   64'(bus_if.fft_wr_en),    64'd0);
        check("rst_fft_wr_addr", 64'(bus_if.fft_wr_addr),  64'd0);
        check("rst_fft_wr_data", bus_if.fft_wr_data,       64'd0);
        check("rst_fft_start",   64'(bus_if.fft_start_oh), 64'd0);
        check("rst_busy",        64'(busy),                64'd0);
        check("rst_ovrn",        64'(ovrn_cnt),            64'd0);
        rst_sync_l = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, L=2.
        t = cyc;
        rdy = 1'b1;
        expect_frame(t + 1, 1'b0);
        @(negedge clk);
        rdy = 1'b0;
        check("basic_busy_rise", 64'(busy), 64'd1);
        check("basic_first_rd",  64'(bus_if.mem_rd_en), 64'd1);
        check("basic_first_adr", 64'(bus_if.mem_addr), 64'd0);
        wait_drain("basic_drain", 200);
        check("basic_busy_fall", 64'(busy_fall_cyc), 64'(t + 13));

        // FFT busy at the frame pulse.
        t = cyc;
        snap_a = rd_cnt;
        rdy = 1'b1;
        bus_if.fft_busy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        repeat (20) @(negedge clk);
        check("fbusy_no_rd", 64'(rd_cnt - snap_a), 64'd0);
        bus_if.fft_busy = 1'b0;
        expect_frame(t + 22, 1'b0);
        wait_drain("fbusy_drain", 200);
        check("fbusy_rd_start", 64'(rd_start_cyc), 64'(t + 22));
        check("fbusy_ovrn", 64'(ovrn_cnt), 64'd0);

        // Overrun pulses at T, T+3, T+9.
        t = cyc;
        snap_a = rd_cnt;
        expect_frame(t + 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rdy = (i == 0 || i == 3 || i == 9);
            @(negedge clk);
        end
        rdy = 1'b0;
        wait_drain("ovrn_drain", 200);
        repeat (10) @(negedge clk);
        check("ovrn_two", 64'(ovrn_cnt), 64'd2);
        check("ovrn_one_frame", 64'(rd_cnt - snap_a), 64'd8);

        // Saturation: hold rdy while the block waits on the FFT.
        t = cyc;
        rdy = 1'b1;
        bus_if.fft_busy = 1'b1;
        repeat (253) @(negedge clk);
        check("ovrn_254", 64'(ovrn_cnt), 64'd254);
        repeat (48) @(negedge clk);
        rdy = 1'b0;
        bus_if.fft_busy = 1'b0;
        check("ovrn_sat", 64'(ovrn_cnt), 64'd255);
        expect_frame(t + 302, 1'b0);
        wait_drain("sat_drain", 200);
        check("ovrn_sat_hold", 64'(ovrn_cnt), 64'd255);

        // Bubbled responses 1-0-1-0.
        t = cyc;
        bubble = 1'b1;
        bub_base = t + 3;
        rdy = 1'b1;
        expect_frame(t + 1, 1'b1);
        @(negedge clk);
        rdy = 1'b0;
        wait_drain("bubble_drain", 200);
        bubble = 1'b0;

        // Reset mid-FETCH with responses arriving after release.
        lat = 6;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.mem_rd_en === 1'b1 && bus_if.mem_addr == 3'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reach_idx4", 64'(found), 64'd1);
        #2;
        rst_sync_l = 1'b0;
        snap_a = wr_seen;
        snap_b = start_seen;
        repeat (3) @(negedge clk);
        #2;
        rst_sync_l = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_no_wr",    64'(wr_seen - snap_a),    64'd0);
        check("rst_no_start", 64'(start_seen - snap_b), 64'd0);
        check("rst_ovrn_clr", 64'(ovrn_cnt), 64'd0);
        lat = 2;
        t = cyc;
        rdy = 1'b1;
        expect_frame(t + 1, 1'b0);
        @(negedge clk);
        rdy = 1'b0;
        wait_drain("rst_next_drain", 200);

        // Stray valid while idle.
        snap_a = wr_seen;
        #2;
        stray_req++;
        repeat (5) @(negedge clk);
        check("stray_no_wr", 64'(wr_seen - snap_a), 64'd0);
        t = cyc;
        rdy = 1'b1;
        expect_frame(t + 1, 1'b0);
        @(negedge clk);
        rdy = 1'b0;
        wait_drain("stray_next_drain", 200);

        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
